// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: word size, field positions, FSM encoding and
// next-PC control bundle shared by the fetch unit files.
package fetch_unit_pkg;

  localparam int WORD_W   = 16;
  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int TGT_W    = OPC_LO;
  localparam int BR_OFF_W = 8;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  typedef struct packed {
    logic jump_reg;
    logic jump;
    logic branch;
    logic branch_taken;
  } pc_ctrl_t;

  function automatic word_t br_off(
    input logic [BR_OFF_W-1:0] off
  );
    return {{(WORD_W-BR_OFF_W){off[BR_OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// next_pc_calc: combinational next-PC select.
// Ports: pc, tgt (inst[11:0]), ctrl, reg_target -> next_pc.
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic [TGT_W-1:0]  tgt,
  input  pc_ctrl_t          ctrl,
  input  logic [WORD_W-1:0] reg_target,
  output logic [WORD_W-1:0] next_pc
);

  logic [WORD_W-1:0] pc_inc;
  logic sel_reg;
  logic sel_jmp;
  logic sel_br;
  logic sel_inc;

  assign pc_inc = pc + WORD_W'(1);

  // priority folded into one-hot selects
  assign sel_reg = ctrl.jump_reg;
  assign sel_jmp = ~ctrl.jump_reg
                 & ctrl.jump;
  assign sel_br  = ~ctrl.jump_reg
                 & ~ctrl.jump
                 & ctrl.branch
                 & ctrl.branch_taken;
  assign sel_inc = ~(sel_reg
                   | sel_jmp
                   | sel_br);

  always_comb begin
    next_pc = pc_inc;
    unique case (1'b1)
      sel_reg: next_pc = reg_target;
      sel_jmp: next_pc = {pc[OPC_HI:OPC_LO],
                          tgt};
      sel_br:  next_pc = pc_inc
                 + br_off(tgt[BR_OFF_W-1:0]);
      sel_inc: next_pc = pc_inc;
      default: next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: FETCH/ISSUE/HALT instruction fetch FSM.
// Ports: clk, reset_n; mem readM/address/data/inputReady;
// issue inst/inst_valid/next_ready/pc_out; control jump,
// branch, branch_taken, HLT, jump_reg, reg_target; halted.
// Define INST_COUNT_EN to add the num_inst accept counter.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  output logic              readM,
  output logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] data,
  input  logic              inputReady,
  output logic [WORD_W-1:0] inst,
  output logic              inst_valid,
  input  logic              next_ready,
  input  logic              jump,
  input  logic              branch,
  input  logic              HLT,
  input  logic              jump_reg,
  input  logic [WORD_W-1:0] reg_target,
  input  logic              branch_taken,
  output logic [WORD_W-1:0] pc_out,
  output logic              halted
`ifdef INST_COUNT_EN
  ,
  output logic [WORD_W-1:0] num_inst
`endif
);

  state_e            state;
  pc_ctrl_t          ctrl;
  logic [WORD_W-1:0] next_pc;
  logic              accept;

  assign ctrl.jump_reg     = jump_reg;
  assign ctrl.jump         = jump;
  assign ctrl.branch       = branch;
  assign ctrl.branch_taken = branch_taken;

  assign accept = (state == S_ISSUE)
                & next_ready;

  next_pc_calc u_npc (
    .pc         (address),
    .tgt        (inst[TGT_W-1:0]),
    .ctrl       (ctrl),
    .reg_target (reg_target),
    .next_pc    (next_pc)
  );

  // address is the PC register itself
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_FETCH;
      readM      <= 1'b0;
      address    <= '0;
      inst       <= '0;
      pc_out     <= '0;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          // readM is low only on the first
          // cycle after reset release
          if (!readM) begin
            readM <= 1'b1;
          end else if (inputReady) begin
            inst       <= data;
            pc_out     <= address;
            inst_valid <= 1'b1;
            readM      <= 1'b0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (next_ready) begin
            address    <= next_pc;
            inst_valid <= 1'b0;
            if (HLT) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              readM <= 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_HALT: begin
        end
        default: begin
          readM      <= 1'b0;
          inst_valid <= 1'b0;
          state      <= S_FETCH;
        end
      endcase
    end
  end

`ifdef INST_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_inst <= '0;
    end else if (accept) begin
      num_inst <= num_inst + WORD_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic, scoreboard of
// expected fetch addresses and issued instructions.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        readM;
  logic [15:0] address;
  logic [15:0] data;
  logic        inputReady;
  logic [15:0] inst;
  logic        inst_valid;
  logic        next_ready;
  logic        jump;
  logic        branch;
  logic        HLT;
  logic        jump_reg;
  logic [15:0] reg_target;
  logic        branch_taken;
  logic [15:0] pc_out;
  logic        halted;
`ifdef INST_COUNT_EN
  logic [15:0] num_inst;
`endif

  fetch_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .readM        (readM),
    .address      (address),
    .data         (data),
    .inputReady   (inputReady),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .next_ready   (next_ready),
    .jump         (jump),
    .branch       (branch),
    .HLT          (HLT),
    .jump_reg     (jump_reg),
    .reg_target   (reg_target),
    .branch_taken (branch_taken),
    .pc_out       (pc_out),
    .halted       (halted)
`ifdef INST_COUNT_EN
   ,.num_inst     (num_inst)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];
  logic [15:0] model_pc = 16'h0;
  int          model_cnt = 0;
  logic        model_halted = 1'b0;
  logic [15:0] last_d = 16'h0;
  logic [15:0] last_pc = 16'h0;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, expv);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // reference next-PC from the architectural rules
  function automatic logic [15:0] model_next(
    input logic [15:0] pc,
    input logic [15:0] ins,
    input logic jr, input logic j,
    input logic br, input logic bt,
    input logic [15:0] rt);
    int off;
    int sum;
    logic [15:0] hi;
    if (jr) return rt;
    if (j) begin
      hi = pc & 16'hF000;
      return hi | (ins & 16'h0FFF);
    end
    if (br && bt) begin
      off = int'(ins & 16'h00FF);
      if (off > 127) off = off - 256;
      sum = (int'(pc) + 1 + off) & 'hFFFF;
      return 16'(sum);
    end
    return 16'((int'(pc) + 1) & 'hFFFF);
  endfunction

  // monitor: pops expectations as the DUT presents them
  initial begin
    logic prev_rd;
    logic prev_iv;
    logic [15:0] ei;
    logic [15:0] ep;
    prev_rd = 1'b0;
    prev_iv = 1'b0;
    ei = 16'h0;
    ep = 16'h0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_rd = 1'b0;
        prev_iv = 1'b0;
      end else begin
        if (readM && !prev_rd) begin
          if (exp_addr_q.size() == 0)
            flag("unexpected_fetch");
          else
            chk("fetch_addr", address,
                exp_addr_q.pop_front());
        end
        if (inst_valid && !prev_iv) begin
          if (exp_inst_q.size() == 0)
            flag("unexpected_issue");
          else
            {ei, ep} = exp_inst_q.pop_front();
        end
        if (inst_valid) begin
          chk("inst", inst, ei);
          chk("pc_out", pc_out, ep);
          chk("readM_in_issue", 16'(readM), 16'h0);
        end
        if (readM)
          chk("iv_in_fetch", 16'(inst_valid), 16'h0);
        chk("halted", 16'(halted), 16'(model_halted));
`ifdef INST_COUNT_EN
        chk("num_inst", num_inst, 16'(model_cnt));
`endif
        prev_rd = readM;
        prev_iv = inst_valid;
      end
    end
  end

  task automatic junk_ctrl();
    jump         = 1'($urandom);
    branch       = 1'($urandom);
    HLT          = 1'($urandom);
    jump_reg     = 1'($urandom);
    branch_taken = 1'($urandom);
    reg_target   = 16'($urandom);
  endtask

  task automatic idle_inputs();
    inputReady   = 1'b0;
    next_ready   = 1'b0;
    data         = 16'h0;
    jump         = 1'b0;
    branch       = 1'b0;
    HLT          = 1'b0;
    jump_reg     = 1'b0;
    branch_taken = 1'b0;
    reg_target   = 16'h0;
  endtask

  // called at posedge+1; reset lands mid-cycle
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_readM", 16'(readM), 16'h0);
    chk("rst_address", address, 16'h0);
    chk("rst_inst", inst, 16'h0);
    chk("rst_pc_out", pc_out, 16'h0);
    chk("rst_inst_valid", 16'(inst_valid), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
`ifdef INST_COUNT_EN
    chk("rst_num_inst", num_inst, 16'h0);
`endif
    exp_addr_q.delete();
    exp_inst_q.delete();
    exp_addr_q.push_back(16'h0);
    model_pc = 16'h0;
    model_cnt = 0;
    model_halted = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    chk("readM_held_rst", 16'(readM), 16'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("readM_after_rel", 16'(readM), 16'h1);
    chk("addr_after_rel", address, 16'h0);
  endtask

  task automatic do_instr(input logic [15:0] d,
                          input int wt, input int st,
                          input logic jr, input logic j,
                          input logic br, input logic bt,
                          input logic hlt,
                          input logic [15:0] rt);
    int n;
    logic [15:0] nxt;
    n = 0;
    while (readM !== 1'b1) begin
      if (n == 20) begin
        flag("fetch_timeout");
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    repeat (wt) begin
      junk_ctrl();
      inputReady = 1'b0;
      next_ready = 1'($urandom);
      data = 16'($urandom);
      @(posedge clk); #1;
    end
    data = d;
    inputReady = 1'b1;
    next_ready = 1'($urandom);
    exp_inst_q.push_back({d, model_pc});
    @(posedge clk); #1;
    repeat (st) begin
      junk_ctrl();
      next_ready = 1'b0;
      inputReady = 1'($urandom);
      data = 16'($urandom);
      @(posedge clk); #1;
    end
    inputReady = 1'($urandom);
    data = 16'($urandom);
    next_ready = 1'b1;
    jump_reg = jr;
    jump = j;
    branch = br;
    branch_taken = bt;
    HLT = hlt;
    reg_target = rt;
    nxt = model_next(model_pc, d, jr, j, br, bt, rt);
    if (!hlt) exp_addr_q.push_back(nxt);
    last_d = d;
    last_pc = model_pc;
    model_pc = nxt;
    @(posedge clk); #1;
    model_cnt++;
    model_halted = hlt;
    idle_inputs();
  endtask

  task automatic plain(input logic [15:0] d,
                       input int wt, input int st);
    do_instr(d, wt, st, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b0, 16'h0);
  endtask

  task automatic goto_pc(input logic [15:0] t);
    do_instr(16'($urandom), 0, 0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, t);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end

  initial begin
    int n;
    idle_inputs();
    @(posedge clk); #1;
    do_reset();

    plain(16'h6001, 3, 0);

    goto_pc(16'h1234);
    do_instr(16'h9ABC, 0, 0, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 16'h0);

    goto_pc(16'h0010);
    do_instr(16'hC0FE, 1, 1, 1'b0, 1'b0, 1'b1,
             1'b1, 1'b0, 16'h0);
    goto_pc(16'h0010);
    do_instr(16'hC0FE, 0, 2, 1'b0, 1'b0, 1'b1,
             1'b0, 1'b0, 16'h0);

    goto_pc(16'hFFFF);
    plain(16'h1111, 0, 5);

    for (int i = 0; i < 150; i++) begin
      do_instr(16'($urandom),
               int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) == 0),
               1'($urandom), 1'($urandom),
               1'b0, 16'($urandom));
    end

    // reset while a read is pending
    n = 0;
    while (readM !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    inputReady = 1'b0;
    @(posedge clk); #1;
    do_reset();

    plain(16'h2222, 0, 0);
    plain(16'h3333, 2, 1);
    do_instr(16'hF000, 1, 1, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b1, 16'h0);

    for (int i = 0; i < 20; i++) begin
      junk_ctrl();
      inputReady = 1'($urandom);
      next_ready = 1'($urandom);
      data = 16'($urandom);
      @(posedge clk); #1;
      chk("halt_readM", 16'(readM), 16'h0);
      chk("halt_iv", 16'(inst_valid), 16'h0);
      chk("halt_inst", inst, last_d);
      chk("halt_pc_out", pc_out, last_pc);
      chk("halt_flag", 16'(halted), 16'h1);
    end

    idle_inputs();
    @(posedge clk); #1;
    if (exp_addr_q.size() != 0)
      flag("addr_q_not_drained");
    if (exp_inst_q.size() != 0)
      flag("inst_q_not_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous reset, active-low.
REQ-003 SHALL have port readM, output, 1 bit: instruction memory read request.
REQ-004 SHALL have port address, output, 16 bits: memory read address (current PC).
REQ-005 SHALL have port data, input, 16 bits: memory read data, valid when inputReady=1.
REQ-006 SHALL have port inputReady, input, 1 bit: memory read completion strobe.
REQ-007 SHALL have port inst, output, 16 bits: instruction register, feeds the control unit.
REQ-008 SHALL have port inst_valid, output, 1 bit: inst holds a fetched, unconsumed instruction.
REQ-009 SHALL have port next_ready, input, 1 bit: downstream accepts inst this cycle.
REQ-010 SHALL have ports jump, branch, HLT, inputs, 1 bit each: control-unit decode of inst.
REQ-011 SHALL have port jump_reg, input, 1 bit: JPR/JRL register-indirect jump.
REQ-012 SHALL have port reg_target, input, 16 bits: register value for jump_reg.
REQ-013 SHALL have port branch_taken, input, 1 bit: branch condition result.
REQ-014 SHALL have port pc_out, output, 16 bits: PC of inst, for link address (pc_out+1).
REQ-015 SHALL have port halted, output, 1 bit: HLT retired, fetch stopped.

Function
REQ-016 SHALL implement FSM states S_FETCH, S_ISSUE, S_HALT.
REQ-017 In S_FETCH SHALL drive readM=1, address=PC; inst_valid=0.
REQ-018 On S_FETCH with inputReady=1 SHALL latch data into inst, PC into pc_out, go to S_ISSUE next cycle; readM=0 in S_ISSUE.
REQ-019 In S_ISSUE SHALL hold inst_valid=1 and inst stable until next_ready=1.
REQ-020 On S_ISSUE with next_ready=1 SHALL update PC from control inputs sampled that same cycle and go to S_FETCH, or to S_HALT if HLT=1.
REQ-021 Next-PC priority SHALL be: jump_reg -> reg_target; jump -> {PC[15:12], inst[11:0]}; branch&&branch_taken -> PC+1+sign-extended inst[7:0]; otherwise PC+1.
REQ-022 PC arithmetic SHALL be 16-bit modulo; 16'hFFFF+1 wraps to 16'h0000.
REQ-023 branch=1 with branch_taken=0 SHALL yield PC+1.
REQ-024 S_HALT SHALL be sticky until reset: readM=0, inst_valid=0, halted=1, inst/pc_out frozen.
REQ-025 Control inputs SHALL be ignored outside the S_ISSUE accept cycle.
REQ-026 inputReady outside S_FETCH SHALL be ignored.
REQ-027 Minimum latency SHALL be 2 cycles per instruction (inputReady in first S_FETCH cycle, next_ready in first S_ISSUE cycle).

Reset
REQ-028 reset_n=0 SHALL immediately force PC=0, state S_FETCH, readM=0, address=0, inst=0, pc_out=0, inst_valid=0, halted=0.
REQ-029 A reset during a pending read SHALL abandon it; first rising edge after release SHALL assert readM with address=0.

Configuration
REQ-030 With INST_COUNT_EN defined SHALL provide output num_inst, 16 bits, reset 0, incremented by 1 (wrapping) on each S_ISSUE accept, including HLT.
REQ-031 Without INST_COUNT_EN SHALL omit num_inst port and counter; all other behaviour identical.

Structure
REQ-032 Word size, opcode field positions, state encodings and branch offset width SHALL reside in the shared header.
REQ-033 Next-PC selection SHALL be a combinational sub-module next_pc_calc.

Verification
REQ-034 Reset, data=16'h6001 with inputReady after 3 wait cycles, next_ready=1 -> address=0, inst=16'h6001, then address=1.
REQ-035 At PC=16'h1234, jump=1, inst=16'h9ABC accepted -> next address=16'h1ABC.
REQ-036 At PC=16'h0010, branch=1, branch_taken=1, inst[7:0]=8'hFE -> next address=16'h000F; branch_taken=0 -> 16'h0011.
REQ-037 next_ready low 5 cycles in S_ISSUE -> inst/inst_valid stable, readM=0; PC=16'hFFFF accepted -> address=0.
REQ-038 HLT=1 accepted -> halted=1, readM stays 0 for 20 cycles; reset_n pulse mid-read -> readM drops at once, refetch from 0; with INST_COUNT_EN, num_inst counts accepts exactly.
